mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the datapath's MAR/MDR interface. Accepts read/write strobes
//  from the control sequencer, waits a configurable number of cycles, then returns the
//  addressed word on Mdatain (read) or stores MDR contents (write). Signals completion
//  with mem_ready using a four-phase handshake. Sits between MAR/MDR and the instruction/data RAM.
// PARAMETERS
//  ADDR_WIDTH   9   word-address bits taken from MAR[ADDR_WIDTH-1:0] (2**ADDR_WIDTH x 32-bit words)
//  WAIT_STATES  2   extra cycles inserted before the access cycle (0..15)
// PORTS
//  clock        in   1   system clock, all state updates on rising edge
//  clear        in   1   asynchronous, active-low reset
//  read         in   1   read request strobe, held until mem_ready seen
//  write        in   1   write request strobe, held until mem_ready seen
//  MAR_addr     in   32  address from MAR; only [ADDR_WIDTH-1:0] used
//  MDR_data     in   32  write data from MDR
//  Mdatain      out  32  read data to MDR input mux (registered)
//  mem_ready    out  1   access complete; high in DONE state
//  mem_err      out  1   read and write sampled high together
// BEHAVIOUR
//  Reset (clear=0, async): state=IDLE, Mdatain=0, mem_ready=0, mem_err=0, counter=0.
//   RAM contents not reset. Reset mid-operation aborts; a write not yet in ACCESS is never performed.
//  States: IDLE, WAIT, ACCESS, DONE.
//  IDLE: sampling edge when exactly one of read/write is 1:
//   latch addr=MAR_addr[ADDR_WIDTH-1:0], wdata=MDR_data, op (rd/wr); cnt<=WAIT_STATES;
//   next = WAIT if WAIT_STATES>0 else ACCESS. mem_err<=0.
//   Both read and write high: mem_err<=1, no access, stay IDLE. Neither: mem_err<=0, stay IDLE.
//  WAIT: if cnt==1 -> ACCESS, else cnt<=cnt-1. Strobe changes ignored.
//  ACCESS (single cycle): rd: Mdatain<=RAM[addr]; wr: RAM[addr]<=wdata. -> DONE.
//  DONE: mem_ready=1 (Moore). Leave to IDLE on first edge where read==0 and write==0.
//   Strobe dropped early (before DONE): operation still completes; mem_ready high exactly one cycle.
//  Latency: mem_ready rises after the (WAIT_STATES+2)th rising edge, counting the sampling edge as 1st.
//  Mdatain holds its last read value until the next read's ACCESS; writes never change it.
//  Address wrap: MAR bits above ADDR_WIDTH ignored (0x200 aliases 0x000 at default).
//  New request cannot be sampled until DONE->IDLE; min spacing WAIT_STATES+3 cycles.
//  Read-after-write to same address returns new data (write completes in its ACCESS cycle).
// TESTING
//  1 Reset: clear=0 mid-WAIT of a write to 0x05 -> IDLE, outputs 0; later read 0x05 != aborted data.
//  2 Write 0x18228000 to 0x0A (W=2): mem_ready rises 4 edges after sample; Mdatain unchanged.
//  3 Read 0x0A: Mdatain=0x18228000 when mem_ready=1; stays after read drops; ready falls next edge.
//  4 read=write=1 -> mem_err=1, no ready, RAM unchanged; drop both -> mem_err=0 next edge.
//  5 Write 0x12 to MAR=0x204, read MAR=0x004 -> 0x00000012 (wrap).
//  6 WAIT_STATES=0 build: read strobe held -> mem_ready high 2nd edge; strobe dropped after 1 cycle -> ready 1-cycle pulse.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control sequencer (master) and the
// memory responder (slave) on the MAR/MDR side of the datapath.
interface mem_responder_if;
  logic        read;
  logic        write;
  logic [31:0] MAR_addr;
  logic [31:0] MDR_data;
  logic [31:0] Mdatain;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output read, write, MAR_addr, MDR_data,
    input  Mdatain, mem_ready, mem_err
  );

  modport slave (
    input  read, write, MAR_addr, MDR_data,
    output Mdatain, mem_ready, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Wait-stated word RAM behind MAR/MDR: samples one read or write strobe, inserts
// WAIT_STATES idle cycles, performs a single-cycle access and holds mem_ready until both strobes drop.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic            clock,
  input  logic            clear,
  mem_responder_if.slave  bus
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [3:0]              cnt_r;
  logic [3:0]              cnt_s;
  logic                    err_r;
  logic                    err_s;
  logic                    capture_s;
  logic                    ready_r;
  logic                    op_wr_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [31:0]             wdata_r;
  logic [31:0]             rdata_r;
  logic [31:0]             ram_r [DEPTH];
  logic                    unused_addr_s;

  // MAR bits above the word address alias onto the same RAM location.
  assign unused_addr_s = ^bus.MAR_addr[31:ADDR_WIDTH];

  assign bus.Mdatain   = rdata_r;
  assign bus.mem_ready = ready_r;
  assign bus.mem_err   = err_r;

  // Next-state, wait counter and error flag decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    err_s     = err_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.read && bus.write) begin
          err_s = 1'b1;
        end else if (bus.read || bus.write) begin
          err_s     = 1'b0;
          capture_s = 1'b1;
          cnt_s     = WAIT_INIT;
          state_s   = (WAIT_INIT != 4'd0) ? ST_WAIT : ST_ACCESS;
        end else begin
          err_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          state_s = ST_ACCESS;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_ACCESS: begin
        state_s = ST_DONE;
      end
      ST_DONE: begin
        // Four-phase close: stay complete until the sequencer releases both strobes.
        if (!bus.read && !bus.write) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      err_r   <= 1'b0;
      ready_r <= 1'b0;
      op_wr_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      ready_r <= (state_s == ST_DONE);
      if (capture_s) begin
        op_wr_r <= bus.write;
        addr_r  <= bus.MAR_addr[ADDR_WIDTH-1:0];
        wdata_r <= bus.MDR_data;
      end else begin
        op_wr_r <= op_wr_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
      if (state_r == ST_ACCESS && !op_wr_r) begin
        rdata_r <= ram_r[addr_r];
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // RAM array is not reset; an aborted request never reaches ACCESS so never writes.
  always_ff @(posedge clock) begin
    if (state_r == ST_ACCESS && op_wr_r) begin
      ram_r[addr_r] <= wdata_r;
    end
  end

endmodule
